// File: rtl/aes_dec_pkg.sv
// Shared types and helpers for the AES-128 decrypt datapath.
package aes_dec_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} invmc_fsm_t;

  localparam logic [7:0] AES_POLY = 8'h1b;

  // x02 multiply in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns of one 32-bit column (byte 0 in bits [31:24]).
module inv_mix_column
  import aes_dec_pkg::*;
(
  input  col_t col_in,
  output col_t col_out
);

  logic [3:0][7:0] a, x2, x4, x8, m9, mb, md, me;

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign a[i]  = col_in[31-8*i -: 8];
    assign x2[i] = xtime(a[i]);
    assign x4[i] = xtime(x2[i]);
    assign x8[i] = xtime(x4[i]);
    assign m9[i] = x8[i] ^ a[i];
    assign mb[i] = x8[i] ^ x2[i] ^ a[i];
    assign md[i] = x8[i] ^ x4[i] ^ a[i];
    assign me[i] = x8[i] ^ x4[i] ^ x2[i];
  end

  // Each output row is the circulant {0e,0b,0d,09} rotated by the row index.
  for (genvar i = 0; i < 4; i++) begin : g_row
    assign col_out[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns: one column per cycle, 5-cycle accept-to-valid latency.
// Optional INVMC_SKIP_EN adds a skip input that passes the state through unchanged.
module inv_mix_columns_seq
  import aes_dec_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
`ifdef INVMC_SKIP_EN
  ,
  input  logic         skip
`endif
);

  invmc_fsm_t fsm_q, fsm_d;
  logic [1:0] col_q, col_d;
  state_t     work_q, work_d;
  logic       in_ready_q, out_valid_q;
  col_t       cur_col, imc_col, new_col;

`ifdef INVMC_SKIP_EN
  logic skip_q, skip_d;
`endif

  assign cur_col = work_q[127-32*col_q -: 32];

  inv_mix_column u_imc (
    .col_in  (cur_col),
    .col_out (imc_col)
  );

`ifdef INVMC_SKIP_EN
  // Final decrypt round has no InvMixColumns; keep the timing identical anyway.
  assign new_col = skip_q ? cur_col : imc_col;
`else
  assign new_col = imc_col;
`endif

  always_comb begin
    fsm_d  = fsm_q;
    col_d  = col_q;
    work_d = work_q;
`ifdef INVMC_SKIP_EN
    skip_d = skip_q;
`endif
    case (fsm_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          work_d = in_state;
          col_d  = 2'd0;
          fsm_d  = BUSY;
`ifdef INVMC_SKIP_EN
          skip_d = skip;
`endif
        end
      end
      BUSY: begin
        work_d[127-32*col_q -: 32] = new_col;
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) fsm_d = DONE;
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      col_q       <= 2'd0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef INVMC_SKIP_EN
      skip_q      <= 1'b0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      col_q       <= col_d;
      work_q      <= work_d;
      in_ready_q  <= (fsm_d == IDLE);
      out_valid_q <= (fsm_d == DONE);
`ifdef INVMC_SKIP_EN
      skip_q      <= skip_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = work_q;

endmodule
